rca_error_sweep_ctrl: RTL
=========================

// Module: rca_error_sweep_ctrl
// PURPOSE
//  Sequencer that sweeps every operand combination through an approximate RCA and an exact reference adder.
//  - Both adders are combinational and sit outside this block.
//  - Per vector it compares the two sums and accumulates error metrics: error count, max and summed error distance.
//  - Sits beside the adder datapath as its characterisation controller; results are read by the test harness or host.
// PARAMETERS
//  WIDTH  8  operand width of the driven adders; sums are WIDTH+1 bits
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           begin a sweep; sampled in IDLE or DONE only
//  abort      in   1           stop the sweep; return to IDLE
//  A_out      out  WIDTH       operand A driven to both adders
//  B_out      out  WIDTH       operand B driven to both adders
//  Cin_out    out  1           carry-in driven to both adders
//  S_approx   in   WIDTH+1     sum from the approximate adder
//  S_exact    in   WIDTH+1     sum from the exact adder
//  busy       out  1           high while in SWEEP
//  done       out  1           level; high in DONE
//  vec_count  out  2*WIDTH+2   vectors evaluated
//  err_count  out  2*WIDTH+2   vectors where S_approx != S_exact
//  max_err    out  WIDTH+1     max |S_exact - S_approx|
//  err_sum    out  3*WIDTH+2   sum of |S_exact - S_approx|; cannot overflow at full sweep
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs and registers are 0; state IDLE.
//  FSM states: IDLE, SWEEP, DONE.
//  - IDLE/DONE, start=1: clear all counters, A_out=B_out=0, Cin_out=0.
//    busy=1 and done=0 on the next edge; go to SWEEP.
//  - SWEEP, each cycle: sample S_approx/S_exact for the operands currently held, then:
//    - vec_count += 1
//    - if the sums differ: err_count += 1
//    - d = |S_exact - S_approx|, computed unsigned at WIDTH+1 bits
//    - max_err = max(max_err, d); err_sum += d
//  - Operand advance, same edge: B_out += 1. On B wrap, A_out += 1. On A wrap, Cin_out toggles (see CONFIGURATION).
//  - Last vector = A=B=all-ones plus final Cin. After sampling it go to DONE: busy=0, done=1.
//    Operands hold their last values.
//  - abort=1 in SWEEP: go to IDLE next edge, busy=0, done=0.
//    Partial results are retained, excluding the aborting cycle's vector.
//  - abort has priority over start and over last-vector completion in the same cycle.
//  - start while in SWEEP is ignored. abort in IDLE/DONE is ignored; DONE results hold.
//  - Latency: a start sampled at edge n means the first vector is sampled at edge n+2.
//    Total sweep = 2^(2*WIDTH+1) SWEEP cycles, or 2^(2*WIDTH) without Cin sweep.
//  - Mid-sweep reset: immediate return to the reset values; no partial results survive.
// CONFIGURATION
//  Macro: RCA_SWEEP_CIN_EN
//  - Defined: Cin is swept 0 then 1; 2^(2*WIDTH+1) vectors; last vector has Cin=1.
//  - Undefined: Cin_out is tied to 0; 2^(2*WIDTH) vectors.
//    Counter widths are unchanged; the MSBs stay 0.
// STRUCTURE
//  Package rca_sweep_pkg:
//  - state enum {IDLE, SWEEP, DONE}
//  - width constants: SUM_W=WIDTH+1, CNT_W=2*WIDTH+2, ACC_W=3*WIDTH+2
//  Sub-module rca_err_dist (combinational): inputs S_exact and S_approx; outputs d and mismatch.
//  Operand counter, FSM and accumulators live in the top module.
// TESTING  (WIDTH=8, RCA_SWEEP_CIN_EN defined unless noted)
//  1. S_approx tied to S_exact, pulse start
//     -> done after 131072 SWEEP cycles; vec_count=131072, err_count=0, max_err=0, err_sum=0.
//  2. S_approx = S_exact ^ 9'h001
//     -> err_count=131072, max_err=1, err_sum=131072.
//  3. Harness forces d=5 only at A=8'hFF, B=8'hFF, Cin=1
//     -> err_count=1, max_err=5, err_sum=5; done rises the edge after that vector.
//  4. abort asserted on the 10th SWEEP cycle
//     -> busy=0, done=0 next edge; vec_count=9; a second start clears all counters to 0.
//  5. rst_n pulsed low mid-sweep (vec_count=1000), asynchronously
//     -> all outputs 0 immediately; start is ignored during SWEEP.
//  6. RCA_SWEEP_CIN_EN undefined
//     -> Cin_out stays 0 throughout; done after 65536 cycles; vec_count=65536.

Source files
------------

// File: rtl/rca_sweep_pkg.sv
// ============================================================================
// Module  : rca_sweep_pkg
// Brief   : Shared state encoding and width helpers for the RCA error sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int acc_w(input int w);
        return 3 * w + 2;
    endfunction

    // Widths for the default 8-bit operand configuration
    localparam int SUM_W = 9;
    localparam int CNT_W = 18;
    localparam int ACC_W = 26;

endpackage

`default_nettype wire

// File: rtl/rca_err_dist.sv
// ============================================================================
// Module  : rca_err_dist
// Brief   : Unsigned error distance |S_exact - S_approx| and mismatch flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_err_dist #(
    parameter int SUM_W = 9
) (
    input  logic [SUM_W-1:0] S_exact,
    input  logic [SUM_W-1:0] S_approx,
    output logic [SUM_W-1:0] d,
    output logic             mismatch
);

    always_comb begin
        d        = '0;
        mismatch = (S_exact != S_approx);
        if (S_exact >= S_approx) begin
            d = S_exact - S_approx;
        end else begin
            d = S_approx - S_exact;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rca_error_sweep_ctrl.sv
// ============================================================================
// Module  : rca_error_sweep_ctrl
// Brief   : Sweeps all operand combinations through an approximate and an
//           exact adder and accumulates error metrics.
//           Optional macro RCA_SWEEP_CIN_EN also sweeps the carry-in.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_error_sweep_ctrl
    import rca_sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     A_out,
    output logic [WIDTH-1:0]     B_out,
    output logic                 Cin_out,
    input  logic [WIDTH:0]       S_approx,
    input  logic [WIDTH:0]       S_exact,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH+1:0]   vec_count,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [WIDTH:0]       max_err,
    output logic [3*WIDTH+1:0]   err_sum
);

    localparam int c_SUM_W = sum_w(WIDTH);
    localparam int c_CNT_W = cnt_w(WIDTH);
    localparam int c_ACC_W = acc_w(WIDTH);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_start;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_cin;
    logic [c_CNT_W-1:0]   r_vec;
    logic [c_CNT_W-1:0]   r_err;
    logic [c_SUM_W-1:0]   r_max;
    logic [c_ACC_W-1:0]   r_sum;
    logic                 w_clear;
    logic                 w_step;
    logic                 w_last;
    logic [c_SUM_W-1:0]   w_d;
    logic                 w_mis;

    rca_err_dist #(
        .SUM_W (c_SUM_W)
    ) u_err_dist (
        .S_exact  (S_exact),
        .S_approx (S_approx),
        .d        (w_d),
        .mismatch (w_mis)
    );

`ifdef RCA_SWEEP_CIN_EN
    assign w_last = (&r_a) && (&r_b) && r_cin;
`else
    assign w_last = (&r_a) && (&r_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (r_start) begin
                    w_state_next = SWEEP;
                    w_clear      = 1'b1;
                end
            end
            SWEEP: begin
                // abort discards the vector currently on the operands
                if (abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_vec   <= '0;
            r_err   <= '0;
            r_max   <= '0;
            r_sum   <= '0;
        end else begin
            // start is only honoured when captured outside SWEEP
            r_start <= start && (r_state != SWEEP);
            if (w_clear) begin
                r_a   <= '0;
                r_b   <= '0;
                r_cin <= 1'b0;
                r_vec <= '0;
                r_err <= '0;
                r_max <= '0;
                r_sum <= '0;
            end else if (w_step) begin
                r_vec <= r_vec + c_CNT_W'(1);
                r_err <= r_err + {{(c_CNT_W-1){1'b0}}, w_mis};
                r_sum <= r_sum + {{(c_ACC_W-c_SUM_W){1'b0}}, w_d};
                if (w_d > r_max) begin
                    r_max <= w_d;
                end
                if (!w_last) begin
                    r_b <= r_b + WIDTH'(1);
                    if (&r_b) begin
                        r_a <= r_a + WIDTH'(1);
`ifdef RCA_SWEEP_CIN_EN
                        if (&r_a) begin
                            r_cin <= ~r_cin;
                        end
`else
                        r_cin <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    assign A_out     = r_a;
    assign B_out     = r_b;
    assign Cin_out   = r_cin;
    assign busy      = (r_state == SWEEP);
    assign done      = (r_state == DONE);
    assign vec_count = r_vec;
    assign err_count = r_err;
    assign max_err   = r_max;
    assign err_sum   = r_sum;

endmodule

`default_nettype wire
